// File: rtl/y86_arb_pkg.sv
// Shared types and constants for the y86 memory-bus arbiter.
package y86_arb_pkg;

  localparam int Y86_WORD_W      = 32;
  localparam int Y86_ARB_MAX_REQ = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Width of a requester index; a single requester bit is still one wide.
  function automatic int arb_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/y86_mem_arbiter_if.sv
// Requester ports plus the shared y86 memory bus.
// Handshake: a requester raises req_valid[i] with we/addr/wdata (and req_lock
// when Y86_ARB_LOCK_EN is defined) and holds them stable until req_ack[i]
// pulses for one cycle; on the following cycle it either drops valid or
// presents its next request. rdata is meaningful while req_ack is high.
interface y86_mem_arbiter_if
  import y86_arb_pkg::*;
#(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_we;
  logic [NREQ*Y86_WORD_W-1:0] req_addr;
  logic [NREQ*Y86_WORD_W-1:0] req_wdata;
`ifdef Y86_ARB_LOCK_EN
  logic [NREQ-1:0]            req_lock;
`endif
  logic [NREQ-1:0]            req_ack;
  logic [Y86_WORD_W-1:0]      rdata;
  logic [1:0]                 arb_owner;
  logic [Y86_WORD_W-1:0]      mem_A;
  logic                       mem_RE;
  logic                       mem_WE;
  logic [Y86_WORD_W-1:0]      mem_out;
  logic [Y86_WORD_W-1:0]      mem_in;

`ifdef Y86_ARB_LOCK_EN
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_lock, mem_in,
    output req_ack, rdata, arb_owner, mem_A, mem_RE, mem_WE, mem_out
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_lock, mem_in,
    input  req_ack, rdata, arb_owner, mem_A, mem_RE, mem_WE, mem_out
  );
`else
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_in,
    output req_ack, rdata, arb_owner, mem_A, mem_RE, mem_WE, mem_out
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_in,
    input  req_ack, rdata, arb_owner, mem_A, mem_RE, mem_WE, mem_out
  );
`endif

endinterface

// File: rtl/y86_rr_pick.sv
// Combinational round-robin picker: first unmasked valid requester searching
// upward from last+1 with wrap-around.
module y86_rr_pick
  import y86_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = arb_idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   last,
  output logic            found,
  output logic [IW-1:0]   winner
);

  // Scan NREQ candidates in priority order; the first hit wins.
  always_comb begin
    logic [IW-1:0] cand;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!found && req[cand] && !mask[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/y86_mem_arbiter.sv
// Round-robin arbiter sharing one y86 memory bus between NREQ requesters.
// Each access holds the bus for MEM_LAT cycles, then acks for one cycle.
// Optional feature: define Y86_ARB_LOCK_EN for locked (atomic RMW) ownership.
module y86_mem_arbiter
  import y86_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  y86_mem_arbiter_if.slave bus,
  output arb_state_t      dbg_state
);

  localparam int IW = arb_idx_w(NREQ);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  arb_state_t      state;
  logic [LW-1:0]   lat_cnt;
  logic [IW-1:0]   last_gnt;
  logic            r_we;
  logic [NREQ-1:0] gnt_oh;
  logic [NREQ-1:0] pick_mask;
  logic            found;
  logic [IW-1:0]   winner;
  logic [Y86_WORD_W-1:0] win_addr;
  logic [Y86_WORD_W-1:0] win_wdata;
  logic            win_we;

`ifdef Y86_ARB_LOCK_EN
  logic            r_lock;
  logic            lock_act;
  logic [IW-1:0]   lock_own;
`endif

  assign dbg_state = state;
  assign gnt_oh    = NREQ'(1) << last_gnt;
  assign win_addr  = bus.req_addr[int'(winner)*Y86_WORD_W +: Y86_WORD_W];
  assign win_wdata = bus.req_wdata[int'(winner)*Y86_WORD_W +: Y86_WORD_W];
  assign win_we    = bus.req_we[winner];

  // Requester being acked sits out this round; a lock owner excludes everyone else.
  always_comb begin
    pick_mask = (state == RESP) ? gnt_oh : '0;
`ifdef Y86_ARB_LOCK_EN
    if (lock_act) pick_mask = pick_mask | ~(NREQ'(1) << lock_own);
`endif
  end

  y86_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (bus.req_valid),
    .mask   (pick_mask),
    .last   (last_gnt),
    .found  (found),
    .winner (winner)
  );

  // Arbiter FSM: grant, hold the bus for MEM_LAT cycles, then ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      last_gnt      <= LAST_RST;
      r_we          <= 1'b0;
      bus.arb_owner <= '0;
      bus.mem_A     <= '0;
      bus.mem_out   <= '0;
      bus.mem_RE    <= 1'b0;
      bus.mem_WE    <= 1'b0;
      bus.rdata     <= '0;
      bus.req_ack   <= '0;
`ifdef Y86_ARB_LOCK_EN
      r_lock        <= 1'b0;
      lock_act      <= 1'b0;
      lock_own      <= '0;
`endif
    end else begin
      bus.req_ack <= '0;
      case (state)
        IDLE, RESP: begin
          if (found) begin
            state         <= ACCESS;
            lat_cnt       <= LAT_INIT;
            last_gnt      <= winner;
            bus.arb_owner <= 2'(winner);
            r_we          <= win_we;
            bus.mem_A     <= win_addr;
            bus.mem_out   <= win_wdata;
            bus.mem_RE    <= !win_we;
            bus.mem_WE    <= win_we;
`ifdef Y86_ARB_LOCK_EN
            r_lock        <= bus.req_lock[winner];
`endif
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (lat_cnt == '0) begin
            if (!r_we) bus.rdata <= bus.mem_in;
            bus.req_ack <= gnt_oh;
            bus.mem_A   <= '0;
            bus.mem_RE  <= 1'b0;
            bus.mem_WE  <= 1'b0;
            state       <= RESP;
`ifdef Y86_ARB_LOCK_EN
            lock_act    <= r_lock;
            lock_own    <= last_gnt;
`endif
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed bench for y86_mem_arbiter (NREQ=3, MEM_LAT=2) with an ack scoreboard.
module tb_y86_mem_arbiter;
  import y86_arb_pkg::*;

  localparam int NREQ    = 3;
  localparam int MEM_LAT = 2;
  localparam int SLOT    = MEM_LAT + 1;
  localparam int SB_W    = 34;

  logic       clk;
  logic       rst;
  arb_state_t dbg_state;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;

  y86_mem_arbiter_if #(.NREQ(NREQ)) bus();

  y86_mem_arbiter #(.NREQ(NREQ), .MEM_LAT(MEM_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  logic [31:0] mem [256];
  assign bus.mem_in = bus.mem_RE ? mem[bus.mem_A[7:0]] : 32'h0;

  initial forever begin
    @(posedge clk);
    if (bus.mem_WE) mem[bus.mem_A[7:0]] = bus.mem_out;
  end

  // ---------------- scoreboard ----------------
  logic [SB_W-1:0] exp_q[$];
  int              ack_cyc_q[$];
  logic [SB_W-1:0] e;
  bit              sb_en = 1'b1;
  bit              we_seen = 1'b0;
  int              ack_cnt [NREQ];
  int              last_ack [NREQ];
  int              max_gap = 0;
  logic [NREQ-1:0] prev_valid = '0;
  logic [NREQ-1:0] prev_ack = '0;
  logic            prev_rst = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ack(input int id, input logic [31:0] d);
    exp_q.push_back({2'(id), d});
  endtask

  initial forever begin
    @(negedge clk);
    if (bus.mem_WE) we_seen = 1'b1;
    if (!rst && !prev_rst)
      for (int i = 0; i < NREQ; i++)
        if (prev_valid[i] && !bus.req_valid[i] && !prev_ack[i])
          chk($sformatf("protocol_valid_drop_req%0d", i), 32'(bus.req_valid[i]), 32'd1);
    if (!rst && |bus.req_ack) begin
      ack_cyc_q.push_back(cyc);
      for (int i = 0; i < NREQ; i++)
        if (bus.req_ack[i]) begin
          if (last_ack[i] >= 0 && cyc - last_ack[i] > max_gap) max_gap = cyc - last_ack[i];
          last_ack[i] = cyc;
          ack_cnt[i]++;
        end
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_ack", 32'(bus.req_ack), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ack_id", 32'(bus.req_ack), 32'(1) << e[33:32]);
          chk("sb_rdata", bus.rdata, e[31:0]);
        end
      end
    end
    prev_valid = bus.req_valid;
    prev_ack   = bus.req_ack;
    prev_rst   = rst;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int id, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid[id]           = 1'b1;
    bus.req_we[id]              = we;
    bus.req_addr[id*32 +: 32]   = addr;
    bus.req_wdata[id*32 +: 32]  = wdata;
  endtask

  task automatic release_req(input int id);
    bus.req_valid[id] = 1'b0;
  endtask

`ifdef Y86_ARB_LOCK_EN
  task automatic set_lock(input int id, input logic l);
    bus.req_lock[id] = l;
  endtask
`endif

  task automatic wait_ack(input int id, output int at);
    int n;
    n  = 0;
    at = -1;
    while (n < 60) begin
      @(negedge clk);
      if (bus.req_ack[id]) begin
        at = cyc;
        break;
      end
      n++;
    end
    n_tests++;
    assert (at >= 0) else begin
      n_fail++;
      $error("FAIL ack_timeout_req%0d: observed no ack expected ack within 60 cycles", id);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    int at;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h30] = 32'hA0A0_0030;
    mem[8'h34] = 32'hB1B1_0034;
    mem[8'h40] = 32'h4040_0040;
    mem[8'h44] = 32'h4444_0044;
    for (int i = 0; i < NREQ; i++) begin
      ack_cnt[i]  = 0;
      last_ack[i] = -1;
    end
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef Y86_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_ack", 32'(bus.req_ack), 32'h0);
    chk("rst_mem_A", bus.mem_A, 32'h0);
    chk("rst_mem_RE", 32'(bus.mem_RE), 32'h0);
    chk("rst_mem_WE", 32'(bus.mem_WE), 32'h0);
    chk("rst_mem_out", bus.mem_out, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_owner", 32'(bus.arb_owner), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Single read by req0
    @(posedge clk); #1;
    t = cyc;
    expect_ack(0, 32'hDEADBEEF);
    drive(0, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rd_mem_RE", 32'(bus.mem_RE), 32'h1);
    chk("rd_mem_WE", 32'(bus.mem_WE), 32'h0);
    chk("rd_mem_A", bus.mem_A, 32'h10);
    chk("rd_owner", 32'(bus.arb_owner), 32'h0);
    wait_ack(0, at);
    chk("rd_latency", 32'(at), 32'(t + SLOT));
    chk("resp_mem_A_zero", bus.mem_A, 32'h0);
    chk("resp_mem_RE_zero", 32'(bus.mem_RE), 32'h0);
    @(posedge clk); #1 release_req(0);

    // Write then read-back by req1; the write leaves rdata untouched
    @(posedge clk); #1;
    t = cyc;
    expect_ack(1, 32'hDEADBEEF);
    drive(1, 1'b1, 32'h20, 32'h1234);
    @(posedge clk);
    for (int k = 0; k < MEM_LAT; k++) begin
      @(negedge clk);
      chk("wr_mem_WE", 32'(bus.mem_WE), 32'h1);
      chk("wr_mem_RE", 32'(bus.mem_RE), 32'h0);
      chk("wr_mem_out", bus.mem_out, 32'h1234);
      chk("wr_mem_A", bus.mem_A, 32'h20);
    end
    wait_ack(1, at);
    chk("wr_latency", 32'(at), 32'(t + SLOT));
    chk("wr_resp_mem_WE_zero", 32'(bus.mem_WE), 32'h0);
    @(posedge clk); #1;
    expect_ack(1, 32'h1234);
    drive(1, 1'b0, 32'h20, 32'h0);
    wait_ack(1, at);
    @(posedge clk); #1 release_req(1);

    // Simultaneous reads from req0 and req1: order 0,1,0,1 at full throughput
    @(posedge clk); #1;
    ack_cyc_q.delete();
    we_seen = 1'b0;
    expect_ack(0, 32'hA0A0_0030);
    expect_ack(1, 32'hB1B1_0034);
    expect_ack(0, 32'hA0A0_0030);
    expect_ack(1, 32'hB1B1_0034);
    t = cyc;
    drive(0, 1'b0, 32'h30, 32'h0);
    drive(1, 1'b0, 32'h34, 32'h0);
    fork
      begin : thr_sim0
        int a;
        for (int k = 0; k < 2; k++) wait_ack(0, a);
        @(posedge clk); #1 release_req(0);
      end
      begin : thr_sim1
        int a;
        for (int k = 0; k < 2; k++) wait_ack(1, a);
        @(posedge clk); #1 release_req(1);
      end
    join
    chk("sim_ack_count", 32'(ack_cyc_q.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < ack_cyc_q.size())
        chk($sformatf("sim_ack_cycle_%0d", k), 32'(ack_cyc_q[k]), 32'(t + SLOT*(k+1)));
    chk("sim_no_mem_WE", 32'(we_seen), 32'h0);

    // Reset during the second ACCESS cycle aborts the access
    @(posedge clk); #1;
    drive(2, 1'b0, 32'h10, 32'hCAFE);
    @(posedge clk);
    @(negedge clk);
    chk("abort_state_access", 32'(dbg_state), 32'(ACCESS));
    chk("abort_owner", 32'(bus.arb_owner), 32'h2);
    @(posedge clk); #1;
    rst = 1'b1;
    release_req(2);
    @(posedge clk);
    @(negedge clk);
    chk("abort_ack", 32'(bus.req_ack), 32'h0);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    chk("abort_mem_A", bus.mem_A, 32'h0);
    chk("abort_mem_RE", 32'(bus.mem_RE), 32'h0);
    chk("abort_mem_out", bus.mem_out, 32'h0);
    chk("abort_rdata", bus.rdata, 32'h0);
    chk("abort_owner_rst", 32'(bus.arb_owner), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    expect_ack(0, 32'hDEADBEEF);
    expect_ack(1, 32'h1234);
    drive(1, 1'b0, 32'h20, 32'h0);
    drive(0, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_owner", 32'(bus.arb_owner), 32'h0);
    wait_ack(0, at);
    @(posedge clk); #1 release_req(0);
    wait_ack(1, at);
    @(posedge clk); #1 release_req(1);

    // Fairness: all three continuously valid for 30 transactions
    @(posedge clk); #1;
    sb_en   = 1'b0;
    max_gap = 0;
    for (int i = 0; i < NREQ; i++) begin
      ack_cnt[i]  = 0;
      last_ack[i] = -1;
    end
    drive(0, 1'b0, 32'h30, 32'h0);
    drive(1, 1'b0, 32'h34, 32'h0);
    drive(2, 1'b0, 32'h10, 32'h0);
    fork
      begin : thr_f0
        int a;
        for (int k = 0; k < 10; k++) wait_ack(0, a);
        @(posedge clk); #1 release_req(0);
      end
      begin : thr_f1
        int a;
        for (int k = 0; k < 10; k++) wait_ack(1, a);
        @(posedge clk); #1 release_req(1);
      end
      begin : thr_f2
        int a;
        for (int k = 0; k < 10; k++) wait_ack(2, a);
        @(posedge clk); #1 release_req(2);
      end
    join
    repeat (2) @(posedge clk);
    #1 sb_en = 1'b1;
    for (int i = 0; i < NREQ; i++)
      chk($sformatf("fair_count_req%0d", i), 32'(ack_cnt[i]), 32'd10);
    chk("fair_max_gap", 32'(max_gap), 32'(NREQ*SLOT));

`ifdef Y86_ARB_LOCK_EN
    // Locked read then unlocked write by req0 while req1 waits
    @(posedge clk); #1;
    expect_ack(0, 32'h4040_0040);
    expect_ack(0, 32'h4040_0040);
    expect_ack(1, 32'h4444_0044);
    set_lock(0, 1'b1);
    drive(0, 1'b0, 32'h40, 32'h0);
    drive(1, 1'b0, 32'h44, 32'h0);
    wait_ack(0, at);
    @(posedge clk); #1;
    set_lock(0, 1'b0);
    drive(0, 1'b1, 32'h40, 32'h5555);
    wait_ack(0, at);
    @(posedge clk); #1 release_req(0);
    wait_ack(1, at);
    @(posedge clk); #1 release_req(1);
`endif

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/y86_mem_arbiter.md
# y86_mem_arbiter

Shares the single y86 memory bus (address, read/write enables, 32-bit data in/out) between `NREQ` requesters, such as two `y86_seq` cores, or one core plus a debug/program loader. Each requester gets a valid/ack port. The arbiter grants one transaction at a time in round-robin order, drives the shared bus for a fixed memory latency, and returns read data with a one-cycle ack pulse. It sits between the requester bus ports and the memory model.

## Interface
- `NREQ`, default 2: number of requesters, 2..4.
- `MEM_LAT`, default 1: cycles the bus is held per access, ≥1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_we` in NREQ: 1 = write, 0 = read.
- `req_addr` in NREQ*32: packed addresses; requester i occupies bits [32i+31:32i].
- `req_wdata` in NREQ*32: packed write data.
- `req_ack` out NREQ: one-cycle completion pulse, one-hot.
- `rdata` out 32: read data, valid while `req_ack` is high.
- `arb_owner` out 2: index of the current/last granted requester.
- `mem_A` out 32: shared bus address.
- `mem_RE` out 1: shared bus read enable.
- `mem_WE` out 1: shared bus write enable.
- `mem_out` out 32: shared bus write data.
- `mem_in` in 32: shared bus read data.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: counter `lat_cnt` runs from MEM_LAT-1 down to 0.
  - RESP: ack cycle.
- Arbitration is evaluated in IDLE and RESP.
  - The winner is the first valid requester searching upward (with wrap) from `last_gnt+1`.
  - In RESP, the requester being acked is masked out of arbitration.
  - With a winner, the next state is ACCESS. Otherwise it is IDLE.
- On the grant edge, the arbiter registers the winner's `addr`, `we` and `wdata` and sets `last_gnt` = winner.
  - `mem_A` and `mem_out` come from the registered copy.
  - `mem_RE` = ACCESS && !we; `mem_WE` = ACCESS && we.
  - All four are constant through ACCESS and zero outside it. `mem_out` holds its last value.
- On the last ACCESS cycle (`lat_cnt`==0), a read captures `mem_in` into `rdata`.
- RESP: `req_ack[gnt]`=1 for exactly one cycle.
  - `rdata` holds until the next read capture.
  - After a write, `rdata` is unchanged.
- Requester rules:
  - Hold valid/we/addr/wdata stable until ack.
  - On the cycle after ack, either deassert valid or present a new request.
- Protocol violation: if valid drops before ack, the arbiter completes the access and still pulses ack. The bench flags this; the RTL does not.
- Reset values: IDLE; `mem_A`/`mem_out`/`rdata`=0; `mem_RE`/`mem_WE`/`req_ack`=0; `last_gnt`=NREQ-1, so requester 0 wins first; `arb_owner`=0.

## Timing
- Idle arbiter, request raised before edge t: ACCESS cycles t+1..t+MEM_LAT, ack in cycle t+MEM_LAT+1.
- Back-to-back throughput: one transaction per MEM_LAT+1 cycles. RESP overlaps the next grant edge.
- Worst-case wait for a continuously requesting port: (NREQ-1)·(MEM_LAT+1) cycles before its grant.
- Simultaneous requests: resolved by round-robin. Ties never starve.
- `rst` during ACCESS or RESP: the access is aborted, no ack is issued, and all outputs reach reset values on the next edge.

## Configuration
- `Y86_ARB_LOCK_EN` defined:
  - Adds input `req_lock` [NREQ] (same stability rules as `req_addr`).
  - A transaction completed with lock=1 makes its requester the owner. Arbitration then considers only the owner until the owner completes a transaction with lock=0. This supports atomic read-modify-write.
  - If the owner's valid is low, the arbiter idles; other requesters wait.
  - Reset clears ownership.
- Not defined: no `req_lock` port, and pure round-robin applies.

## Structure
- Package `y86_arb_pkg`:
  - `arb_state_t` enum: IDLE/ACCESS/RESP.
  - `Y86_WORD_W`=32.
  - `Y86_ARB_MAX_REQ`=4.
  - Function `arb_idx_w(n)` for index width.
- Sub-module `y86_rr_pick`: combinational round-robin picker. Inputs are the request vector, mask and last grant; outputs are `found` and `winner` index.
- The top level holds the FSM, latency counter, registered request copy, rdata, and (under the macro) the owner register.

## Test plan
- Single read, MEM_LAT=1: req0 read addr 0x10 at cycle 1, with memory driving 0xDEADBEEF → `mem_RE`=1 and `mem_A`=0x10 in cycle 2; `req_ack`=01 and `rdata`=0xDEADBEEF in cycle 3.
- Simultaneous, MEM_LAT=2: req0 and req1 both read from cycle 1 → grant order 0,1,0,1. Acks at cycles 4, 7, 10, 13. `mem_WE` is never asserted.
- Write then read-back: req1 writes 0x1234 to 0x20, then reads 0x20 → `mem_WE`=1 with `mem_out`=0x1234 for MEM_LAT cycles; the read returns 0x1234; `rdata` is unchanged by the write.
- Reset mid-access: `rst` asserted during the second ACCESS cycle with MEM_LAT=3 → no ack; next cycle all outputs are 0; the following request from req1 loses to req0 if both are valid.
- Fairness, NREQ=3: all three requesters continuously valid for 30 transactions → each acked exactly 10 times; no port waits longer than 2·(MEM_LAT+1) cycles.
- Lock (`Y86_ARB_LOCK_EN`): req0 does a locked read of 0x40, then an unlocked write of 0x40, while req1 is valid throughout → req1 is not granted until after req0's write ack.
